// File: rtl/l1_cache_client.sv
// Direct-mapped, write-through L1 cache in front of the SDRAM controller.
// Read misses fill a whole 8-word line with one burst; writes always go to SDRAM.
module l1_cache_client #(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_BITS  = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [31:0]          cpu_data,
    input  logic                 cpu_we,
    input  logic                 cpu_start,
    output logic [31:0]          cpu_q,
    output logic                 cpu_done,
    input  logic                 cache_clear,
    output logic [ADDR_BITS-1:0] sdc_addr,
    output logic [31:0]          sdc_data,
    output logic                 sdc_we,
    output logic                 sdc_start,
    input  logic [255:0]         sdc_q,
    input  logic                 sdc_ack,
    input  logic                 sdc_busy
);

    localparam int TAG_BITS = ADDR_BITS - 3 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, FILL_REQ, FILL_WAIT, WR_REQ, WR_WAIT, DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_BITS-1:0]  lat_addr;
    logic [31:0]           lat_data;
    logic                  lat_we;
    logic [LINES-1:0]      valid;
    logic                  clear_pending;

    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [255:0]          data_mem [LINES];
    logic [TAG_BITS-1:0]   tag_rd;
    logic [255:0]          data_rd;
    logic [255:0]          data_merged;

    logic [INDEX_BITS-1:0] cpu_idx, lat_idx;
    logic [TAG_BITS-1:0]   lat_tag;
    logic [2:0]            lat_off;
    logic                  hit;

    logic do_clear, accept, read_hit, write_hit;
    logic fill_issue, wr_issue, fill_ack, req_ack;

    assign cpu_idx = cpu_addr[2+INDEX_BITS:3];
    assign lat_idx = lat_addr[2+INDEX_BITS:3];
    assign lat_tag = lat_addr[ADDR_BITS-1:3+INDEX_BITS];
    assign lat_off = lat_addr[2:0];
    assign hit     = valid[lat_idx] && (tag_rd == lat_tag);

    always_comb begin
        data_merged                      = data_rd;
        data_merged[{lat_off, 5'd0} +: 32] = lat_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_clear   = 1'b0;
        accept     = 1'b0;
        read_hit   = 1'b0;
        write_hit  = 1'b0;
        fill_issue = 1'b0;
        wr_issue   = 1'b0;
        fill_ack   = 1'b0;
        req_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (clear_pending || cache_clear) begin
                    do_clear = 1'b1;
                end else if (cpu_start) begin
                    accept     = 1'b1;
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lat_we) begin
                    write_hit  = hit;
                    state_next = WR_REQ;
                end else if (hit) begin
                    read_hit   = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = FILL_REQ;
                end
            end
            FILL_REQ: begin
                if (!sdc_busy) begin
                    fill_issue = 1'b1;
                    state_next = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (sdc_ack) begin
                    fill_ack   = 1'b1;
                    req_ack    = 1'b1;
                    state_next = DONE;
                end
            end
            WR_REQ: begin
                if (!sdc_busy) begin
                    wr_issue   = 1'b1;
                    state_next = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (sdc_ack) begin
                    req_ack    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_addr      <= '0;
            lat_data      <= '0;
            lat_we        <= 1'b0;
            valid         <= '0;
            clear_pending <= 1'b0;
            cpu_q         <= '0;
            cpu_done      <= 1'b0;
            sdc_start     <= 1'b0;
            sdc_we        <= 1'b0;
            sdc_addr      <= '0;
            sdc_data      <= '0;
        end else begin
            cpu_done <= (state == DONE);
            if (accept) begin
                lat_addr <= cpu_addr;
                lat_data <= cpu_data;
                lat_we   <= cpu_we;
            end
            // A clear seen outside IDLE is deferred so an in-flight fill can finish first.
            if (do_clear) begin
                valid         <= '0;
                clear_pending <= 1'b0;
            end else if (cache_clear) begin
                clear_pending <= 1'b1;
            end
            if (fill_ack) begin
                valid[lat_idx] <= 1'b1;
                cpu_q          <= sdc_q[{lat_off, 5'd0} +: 32];
            end
            if (read_hit) cpu_q <= data_rd[{lat_off, 5'd0} +: 32];
            if (fill_issue) begin
                sdc_start <= 1'b1;
                sdc_we    <= 1'b0;
                sdc_addr  <= {lat_tag, lat_idx, 3'b000};
            end
            if (wr_issue) begin
                sdc_start <= 1'b1;
                sdc_we    <= 1'b1;
                sdc_addr  <= lat_addr;
                sdc_data  <= lat_data;
            end
            if (req_ack) sdc_start <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_rd  <= tag_mem[cpu_idx];
            data_rd <= data_mem[cpu_idx];
        end
        if (write_hit) data_mem[lat_idx] <= data_merged;
        if (fill_ack) begin
            data_mem[lat_idx] <= sdc_q;
            tag_mem[lat_idx]  <= lat_tag;
        end
    end

endmodule

// File: tb/tb_l1_cache_client.sv
// Scoreboard bench for l1_cache_client with a small SDRAM controller model.
module tb_l1_cache_client;

    logic         clk = 1'b0;
    logic         reset;
    logic [23:0]  cpu_addr;
    logic [31:0]  cpu_data;
    logic         cpu_we;
    logic         cpu_start;
    logic [31:0]  cpu_q;
    logic         cpu_done;
    logic         cache_clear;
    logic [23:0]  sdc_addr;
    logic [31:0]  sdc_data;
    logic         sdc_we;
    logic         sdc_start;
    logic [255:0] sdc_q;
    logic         sdc_ack;
    logic         sdc_busy;

    always #5 clk = ~clk;

    l1_cache_client #(.INDEX_BITS(7), .ADDR_BITS(24)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_we(cpu_we),
        .cpu_start(cpu_start), .cpu_q(cpu_q), .cpu_done(cpu_done),
        .cache_clear(cache_clear),
        .sdc_addr(sdc_addr), .sdc_data(sdc_data), .sdc_we(sdc_we),
        .sdc_start(sdc_start), .sdc_q(sdc_q), .sdc_ack(sdc_ack), .sdc_busy(sdc_busy)
    );

    typedef struct {
        bit          is_read;
        logic [31:0] q;
        string       name;
    } exp_t;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [31:0] data;
    } req_t;

    exp_t sb[$];
    req_t sdc_exp[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_req  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Completion monitor: every cpu_done pops one expected response.
    always @(negedge clk) begin
        if (!reset && cpu_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got cpu_done=1 expected no completion");
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_read) chk(mon_e.name, cpu_q, mon_e.q);
            end
        end
    end

    // SDRAM model: fixed 3-cycle access, burst word k = 0xA000_0000 + k.
    initial begin : sdram
        bit   serving;
        int   cnt;
        req_t r;
        serving = 0;
        cnt     = 0;
        sdc_ack = 1'b0;
        for (int k = 0; k < 8; k++) sdc_q[32*k +: 32] = 32'hA000_0000 + 32'(k);
        forever begin
            @(posedge clk); #1;
            sdc_ack = 1'b0;
            if (reset) begin
                serving = 0;
                continue;
            end
            if (serving) begin
                cnt--;
                if (cnt == 0) begin
                    sdc_ack = 1'b1;
                    serving = 0;
                end
            end else if (sdc_start) begin
                serving = 1;
                cnt     = 3;
                n_req++;
                if (sdc_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sdc_req: got addr %h we %b expected none", sdc_addr, sdc_we);
                end else begin
                    r = sdc_exp.pop_front();
                    chk("sdc_we", 32'(sdc_we), 32'(r.we));
                    chk("sdc_addr", 32'(sdc_addr), 32'(r.addr));
                    if (r.we) chk("sdc_data", sdc_data, r.data);
                end
            end
        end
    end

    task automatic cpu_req(input logic we, input logic [23:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_q, input string name, output int lat);
        exp_t e;
        e.is_read = !we;
        e.q       = exp_q;
        e.name    = name;
        sb.push_back(e);
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_data  = data;
        cpu_start = 1'b1;
        lat       = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!cpu_done && lat < 300);
        cpu_start = 1'b0;
        if (!cpu_done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no cpu_done after %0d cycles expected completion", name, lat);
        end
    endtask

    task automatic push_sdc(input logic we, input logic [23:0] addr, input logic [31:0] data);
        req_t r;
        r.we   = we;
        r.addr = addr;
        r.data = data;
        sdc_exp.push_back(r);
    endtask

    task automatic gap();
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat, lat2, base;
        reset       = 1'b1;
        cpu_addr    = '0;
        cpu_data    = '0;
        cpu_we      = 1'b0;
        cpu_start   = 1'b0;
        cache_clear = 1'b0;
        sdc_busy    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_q", cpu_q, 32'h0);
        chk("rst_cpu_done", 32'(cpu_done), 32'h0);
        chk("rst_sdc_start", 32'(sdc_start), 32'h0);
        chk("rst_sdc_we", 32'(sdc_we), 32'h0);
        chk("rst_sdc_addr", 32'(sdc_addr), 32'h0);
        chk("rst_sdc_data", sdc_data, 32'h0);
        reset = 1'b0;
        gap();

        // Cold read miss fills line 0x120.
        base = n_req;
        push_sdc(1'b0, 24'h000120, 32'h0);
        cpu_req(1'b0, 24'h000123, 32'h0, 32'hA000_0003, "cold_read_q", lat);
        chk("cold_read_reqs", 32'(n_req - base), 32'd1);
        gap();

        // Hit on offset 7 of the same line.
        base = n_req;
        cpu_req(1'b0, 24'h000127, 32'h0, 32'hA000_0007, "hit_off7_q", lat);
        chk("hit_latency", 32'(lat), 32'd3);
        chk("hit_reqs", 32'(n_req - base), 32'd0);
        gap();

        // Write hit: single SDRAM write, then a read sees the new word.
        base = n_req;
        push_sdc(1'b1, 24'h000121, 32'hDEAD_BEEF);
        cpu_req(1'b1, 24'h000121, 32'hDEAD_BEEF, 32'h0, "wr_hit", lat);
        chk("wr_hit_reqs", 32'(n_req - base), 32'd1);
        gap();
        base = n_req;
        cpu_req(1'b0, 24'h000121, 32'h0, 32'hDEAD_BEEF, "rd_after_wr_q", lat);
        chk("rd_after_wr_reqs", 32'(n_req - base), 32'd0);
        gap();

        // Write miss does not allocate.
        base = n_req;
        push_sdc(1'b1, 24'h004000, 32'h1234_5678);
        cpu_req(1'b1, 24'h004000, 32'h1234_5678, 32'h0, "wr_miss", lat);
        chk("wr_miss_reqs", 32'(n_req - base), 32'd1);
        gap();
        base = n_req;
        push_sdc(1'b0, 24'h004000, 32'h0);
        cpu_req(1'b0, 24'h004000, 32'h0, 32'hA000_0000, "rd_after_wr_miss_q", lat);
        chk("rd_after_wr_miss_reqs", 32'(n_req - base), 32'd1);
        gap();

        // Controller busy for 10 cycles around a miss.
        sdc_busy = 1'b1;
        push_sdc(1'b0, 24'h000200, 32'h0);
        fork
            cpu_req(1'b0, 24'h000200, 32'h0, 32'hA000_0000, "busy_miss_q", lat);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk); #1;
                    chk("sdc_start_while_busy", 32'(sdc_start), 32'h0);
                end
                sdc_busy = 1'b0;
                @(posedge clk); #1;
                chk("sdc_start_after_busy", 32'(sdc_start), 32'h1);
            end
        join
        gap();

        // Clear pulsed while the fill is outstanding.
        push_sdc(1'b0, 24'h000300, 32'h0);
        fork
            cpu_req(1'b0, 24'h000305, 32'h0, 32'hA000_0005, "clr_fill_q", lat);
            begin
                int w;
                w = 0;
                while (!sdc_start && w < 100) begin
                    @(posedge clk); #1;
                    w++;
                end
                cache_clear = 1'b1;
                @(posedge clk); #1;
                cache_clear = 1'b0;
            end
        join
        gap();
        base = n_req;
        push_sdc(1'b0, 24'h000300, 32'h0);
        cpu_req(1'b0, 24'h000302, 32'h0, 32'hA000_0002, "after_clr_q", lat);
        chk("after_clr_reqs", 32'(n_req - base), 32'd1);
        gap();
        base = n_req;
        push_sdc(1'b0, 24'h000120, 32'h0);
        cpu_req(1'b0, 24'h000125, 32'h0, 32'hA000_0005, "old_line_cleared_q", lat);
        chk("old_line_cleared_reqs", 32'(n_req - base), 32'd1);
        gap();

        // Top index / top tag.
        push_sdc(1'b0, 24'hFFFFF8, 32'h0);
        cpu_req(1'b0, 24'hFFFFFF, 32'h0, 32'hA000_0007, "top_miss_q", lat);
        gap();
        base = n_req;
        cpu_req(1'b0, 24'hFFFFFC, 32'h0, 32'hA000_0004, "top_hit_q", lat2);
        chk("top_hit_latency", 32'(lat2), 32'd3);
        chk("top_hit_reqs", 32'(n_req - base), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("sdc_exp_drained", 32'(sdc_exp.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
